// File: rtl/bitpack_pkg.sv
// Shared types and helpers for the 1-bit to 8-bit packing FIFO.
// Holds the byte/lane widths, the count type and the lane mapping function.
package bitpack_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned LANE_W     = 3;
   localparam int unsigned DEF_ADDR_W = 9;

   typedef logic [BYTE_W-1:0]   byte_t;
   typedef logic [LANE_W-1:0]   lane_t;
   typedef logic [DEF_ADDR_W:0] cnt_t;

   // Map the arrival order of a bit to its lane in the byte.
   function automatic lane_t lane_idx(input lane_t bit_cnt, input bit msb_first);
      lane_t idx;
      if (msb_first) idx = lane_t'(BYTE_W - 1) - bit_cnt;
      else           idx = bit_cnt;
      return idx;
   endfunction

endpackage

// File: rtl/bitpack_fifo_s1_s8_assembler.sv
// Collects serial bits into a byte and emits a commit pulse when the byte
// completes or when a flush finds a non-empty partial byte.
module bitpack_assembler
   import bitpack_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  di,
   input  logic  wr_en,
   input  logic  flush,
   output lane_t bit_cnt,
   output logic  commit_c,
   output byte_t commit_data_c
);

   localparam int unsigned FILL_W = LANE_W + 1;

   byte_t             asm_q;
   byte_t             asm_nxt;
   logic [FILL_W-1:0] fill_nxt;

   // Fold the accepted bit in first so a same-cycle flush sees it.
   always_comb begin
      asm_nxt = asm_q;
      if (wr_en) begin
         asm_nxt[lane_idx(bit_cnt, MSB_FIRST)] = di;
      end
      fill_nxt      = {1'b0, bit_cnt} + FILL_W'(wr_en);
      commit_c      = fill_nxt[LANE_W] || (flush && (fill_nxt != '0));
      commit_data_c = asm_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         asm_q   <= '0;
         bit_cnt <= '0;
      end else if (commit_c) begin
         asm_q   <= '0;
         bit_cnt <= '0;
      end else begin
         asm_q   <= asm_nxt;
         bit_cnt <= fill_nxt[LANE_W-1:0];
      end
   end

endmodule

// File: rtl/bitpack_fifo_s1_s8.sv
// Single-clock FIFO taking 1-bit writes and returning 8-bit reads.
// Bit n lands in byte n/8 at lane n%8 (mirrored when MSB_FIRST=1).
module bitpack_fifo_s1_s8
   import bitpack_pkg::*;
#(
   parameter int unsigned DEPTH     = 512,
   parameter int unsigned ADDR_W    = 9,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              DI,
   input  logic              WE,
   input  logic              FLUSH,
   input  logic              RE,
   output logic [7:0]        DO,
   output logic              DO_VALID,
   output logic              FULL,
   output logic              EMPTY,
   output logic [ADDR_W:0]   BYTE_CNT,
   output logic [2:0]        BIT_CNT,
   output logic              OVF,
   output logic              UDF
);

   localparam int unsigned   CNT_W     = ADDR_W + 1;
   localparam logic [ADDR_W:0] DEPTH_CNT = CNT_W'(DEPTH);

   byte_t             mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              wr_ok;
   logic              rd_ok;
   logic              commit_c;
   byte_t             commit_data_c;
   logic [ADDR_W:0]   cnt_nxt;

   // FULL blocks writes outright, so a full FIFO never holds partial bits.
   bitpack_assembler #(
      .MSB_FIRST (MSB_FIRST)
   ) u_asm (
      .clk           (CLK),
      .rst           (RST),
      .di            (DI),
      .wr_en         (wr_ok),
      .flush         (FLUSH),
      .bit_cnt       (BIT_CNT),
      .commit_c      (commit_c),
      .commit_data_c (commit_data_c)
   );

   always_comb begin
      wr_ok   = WE && !FULL;
      rd_ok   = RE && !EMPTY;
      cnt_nxt = BYTE_CNT;
      case ({commit_c, rd_ok})
         2'b10:   cnt_nxt = BYTE_CNT + CNT_W'(1);
         2'b01:   cnt_nxt = BYTE_CNT - CNT_W'(1);
         default: cnt_nxt = BYTE_CNT;
      endcase
   end

   // Storage has no reset; stale entries are unreachable once pointers reset.
   always_ff @(posedge CLK) begin
      if (!RST && commit_c) begin
         mem[wr_ptr] <= commit_data_c;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         BYTE_CNT <= '0;
         DO       <= '0;
         DO_VALID <= 1'b0;
         FULL     <= 1'b0;
         EMPTY    <= 1'b1;
         OVF      <= 1'b0;
         UDF      <= 1'b0;
      end else begin
         if (commit_c) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            DO     <= mem[rd_ptr];
         end
         DO_VALID <= rd_ok;
         BYTE_CNT <= cnt_nxt;
         FULL     <= (cnt_nxt == DEPTH_CNT);
         EMPTY    <= (cnt_nxt == '0);
         OVF      <= WE && FULL;
         UDF      <= RE && EMPTY;
      end
   end

endmodule

// File: tb/tb_bitpack_fifo_s1_s8.sv
// Directed bench for bitpack_fifo_s1_s8 (DEPTH=512, LSB-first packing).
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_bitpack_fifo_s1_s8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       di = 1'b0;
   logic       we = 1'b0;
   logic       flush = 1'b0;
   logic       re = 1'b0;
   logic [7:0] dout;
   logic       dv;
   logic       full;
   logic       empty;
   logic [9:0] byte_cnt;
   logic [2:0] bit_cnt;
   logic       ovf;
   logic       udf;

   int n_assert = 0;
   int n_fail   = 0;

   bitpack_fifo_s1_s8 #(
      .DEPTH     (512),
      .ADDR_W    (9),
      .MSB_FIRST (1'b0)
   ) dut (
      .CLK      (clk),
      .RST      (rst),
      .DI       (di),
      .WE       (we),
      .FLUSH    (flush),
      .RE       (re),
      .DO       (dout),
      .DO_VALID (dv),
      .FULL     (full),
      .EMPTY    (empty),
      .BYTE_CNT (byte_cnt),
      .BIT_CNT  (bit_cnt),
      .OVF      (ovf),
      .UDF      (udf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_bit(input logic b);
      we = 1'b1;
      di = b;
      tick();
      we = 1'b0;
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] seq;
      logic [7:0] acc;
      logic [7:0] exp_b;
      int         bc;
      int         n_read;
      int         n_ovf;
      int         n_udf;
      logic [7:0] q[$];

      // Reset state
      tick();
      rst = 1'b0;
      check("rst_empty",    32'(empty),    32'd1);
      check("rst_full",     32'(full),     32'd0);
      check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
      check("rst_bit_cnt",  32'(bit_cnt),  32'd0);
      check("rst_do",       32'(dout),     32'h00);
      check("rst_dv",       32'(dv),       32'd0);

      // Read on a fresh FIFO underflows
      re = 1'b1;
      tick();
      re = 1'b0;
      check("udf_pulse", 32'(udf),  32'd1);
      check("udf_dv",    32'(dv),   32'd0);
      check("udf_do",    32'(dout), 32'h00);
      tick();
      check("udf_clear", 32'(udf),  32'd0);

      // One full byte 1,0,1,1,0,0,1,0 -> 8'h4D
      seq = 8'b0100_1101;
      for (int i = 0; i < 7; i++) wr_bit(seq[i]);
      check("b7_bit_cnt", 32'(bit_cnt), 32'd7);
      check("b7_empty",   32'(empty),   32'd1);
      wr_bit(seq[7]);
      check("b8_empty",    32'(empty),    32'd0);
      check("b8_byte_cnt", 32'(byte_cnt), 32'd1);
      check("b8_bit_cnt",  32'(bit_cnt),  32'd0);
      re = 1'b1;
      tick();
      re = 1'b0;
      check("rd1_dv",       32'(dv),       32'd1);
      check("rd1_do",       32'(dout),     32'h4D);
      check("rd1_byte_cnt", 32'(byte_cnt), 32'd0);
      check("rd1_empty",    32'(empty),    32'd1);
      tick();
      check("rd1_dv_clear", 32'(dv),   32'd0);
      check("rd1_do_hold",  32'(dout), 32'h4D);

      // Partial byte flush 1,1,1 -> 8'h07
      for (int i = 0; i < 3; i++) wr_bit(1'b1);
      check("fl_bit_cnt3", 32'(bit_cnt), 32'd3);
      flush = 1'b1;
      tick();
      check("fl_bit_cnt0",  32'(bit_cnt),  32'd0);
      check("fl_byte_cnt1", 32'(byte_cnt), 32'd1);
      tick();
      flush = 1'b0;
      check("fl_noop_byte_cnt", 32'(byte_cnt), 32'd1);
      re = 1'b1;
      tick();
      re = 1'b0;
      check("fl_rd_dv", 32'(dv),   32'd1);
      check("fl_rd_do", 32'(dout), 32'h07);

      // Flush together with the 8th bit commits only once
      for (int i = 0; i < 7; i++) wr_bit(1'b1);
      we    = 1'b1;
      di    = 1'b1;
      flush = 1'b1;
      tick();
      we    = 1'b0;
      flush = 1'b0;
      check("fl8_byte_cnt", 32'(byte_cnt), 32'd1);
      check("fl8_bit_cnt",  32'(bit_cnt),  32'd0);
      re = 1'b1;
      tick();
      re = 1'b0;
      check("fl8_rd_do", 32'(dout), 32'hFF);

      // Fill all 512 bytes, byte k = k ^ 8'hA5
      for (int k = 0; k < 512; k++) begin
         if (k == 511) begin
            check("fill_511_cnt",  32'(byte_cnt), 32'd511);
            check("fill_511_full", 32'(full),     32'd0);
         end
         pat = 8'(k) ^ 8'hA5;
         for (int i = 0; i < 8; i++) wr_bit(pat[i]);
      end
      check("fill_full", 32'(full),     32'd1);
      check("fill_cnt",  32'(byte_cnt), 32'd512);
      wr_bit(1'b1);
      check("ovf1_pulse", 32'(ovf),      32'd1);
      check("ovf1_cnt",   32'(byte_cnt), 32'd512);
      check("ovf1_bits",  32'(bit_cnt),  32'd0);
      we = 1'b1;
      di = 1'b1;
      re = 1'b1;
      tick();
      we = 1'b0;
      re = 1'b0;
      check("ovf2_pulse", 32'(ovf),      32'd1);
      check("ovf2_dv",    32'(dv),       32'd1);
      check("ovf2_do",    32'(dout),     32'hA5);
      check("ovf2_cnt",   32'(byte_cnt), 32'd511);
      check("ovf2_full",  32'(full),     32'd0);
      check("ovf2_bits",  32'(bit_cnt),  32'd0);
      tick();
      check("ovf_clear", 32'(ovf), 32'd0);
      re = 1'b1;
      tick();
      re = 1'b0;
      check("fill_rd1_do", 32'(dout), 32'hA4);

      // Streaming 10000 bits with concurrent reads
      rst = 1'b1;
      tick();
      rst = 1'b0;
      acc    = '0;
      bc     = 0;
      n_read = 0;
      n_ovf  = 0;
      n_udf  = 0;
      for (int n = 0; n < 10000; n++) begin
         we = 1'b1;
         di = 1'($urandom_range(0, 1));
         re = !empty;
         tick();
         acc[bc] = di;
         bc++;
         if (bc == 8) begin
            q.push_back(acc);
            acc = '0;
            bc  = 0;
         end
         if (ovf) n_ovf++;
         if (udf) n_udf++;
         if (dv) begin
            exp_b = (q.size() != 0) ? q.pop_front() : 8'hxx;
            check("stream_byte", 32'(dout), 32'(exp_b));
            n_read++;
         end
      end
      we = 1'b0;
      for (int i = 0; i < 40 && (q.size() != 0); i++) begin
         re = !empty;
         tick();
         if (udf) n_udf++;
         if (dv) begin
            exp_b = q.pop_front();
            check("stream_byte", 32'(dout), 32'(exp_b));
            n_read++;
         end
      end
      re = 1'b0;
      check("stream_drained", 32'(q.size()), 32'd0);
      check("stream_nread",   32'(n_read),   32'd1250);
      check("stream_ovf",     32'(n_ovf),    32'd0);
      check("stream_udf",     32'(n_udf),    32'd0);

      // Reset mid-operation with a same-cycle read
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 44; i++) wr_bit(1'($urandom_range(0, 1)));
      check("mid_byte_cnt", 32'(byte_cnt), 32'd5);
      check("mid_bit_cnt",  32'(bit_cnt),  32'd4);
      rst = 1'b1;
      re  = 1'b1;
      tick();
      rst = 1'b0;
      re  = 1'b0;
      check("mid_rst_dv",    32'(dv),       32'd0);
      check("mid_rst_empty", 32'(empty),    32'd1);
      check("mid_rst_bits",  32'(bit_cnt),  32'd0);
      check("mid_rst_cnt",   32'(byte_cnt), 32'd0);
      check("mid_rst_do",    32'(dout),     32'h00);
      tick();
      check("mid_rst_dv2", 32'(dv), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
